// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue.
//   UART_DATA_W  : width of one transmitted character
//   tx_q_state_t : states of the queue-to-transmitter handoff sequencer
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a queued byte and an idle transmitter
        REQ  = 2'd1,   // wr_en asserted, waiting for Tx_busy acknowledge
        SEND = 2'd2    // transmitter busy with the byte, waiting for it to finish
    } tx_q_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bundle of the user-side push port and the transmitter-side handoff port
// of the UART transmit queue.
//   push/push_data/flush       : user logic -> queue
//   full/empty/count/overflow  : queue status -> user logic
//   data_in/wr_en              : queue -> transmitter
//   Tx_busy                    : transmitter -> queue
// master = user logic plus transmitter, slave = the queue itself.
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic                   push;
    logic [UART_DATA_W-1:0] push_data;
    logic                   flush;
    logic                   full;
    logic                   empty;
    logic [AW:0]            count;
    logic                   overflow;
    logic [UART_DATA_W-1:0] data_in;
    logic                   wr_en;
    logic                   Tx_busy;

    modport master (
        output push, push_data, flush, Tx_busy,
        input  full, empty, count, overflow, data_in, wr_en
    );

    modport slave (
        input  push, push_data, flush, Tx_busy,
        output full, empty, count, overflow, data_in, wr_en
    );

endinterface

// File: rtl/uart_tx_queue_fifo.sv
// sync_fifo: single-clock circular buffer with registered read.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : enqueue push_data (ignored while full or flushing)
//   pop        : load head into rd_data and advance (ignored while empty)
//   flush      : clear pointers and count; rd_data is left untouched so a
//                byte already handed out stays stable
//   rd_data    : last popped word (registered)
//   full/empty/count : registered occupancy, reflecting the last edge
module sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg,  count_next;
    logic          full_reg,   empty_reg;
    logic [W-1:0]  rd_data_reg;
    logic          push_ok, pop_ok;

    // Acceptance uses the registered flags: a push while full is dropped
    // even if a pop frees a slot on the same edge.
    assign push_ok = push && !full_reg && !flush;
    assign pop_ok  = pop  && !empty_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + (AW+1)'(1);
                2'b01:   count_next = count_reg - (AW+1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            empty_reg   <= 1'b1;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == (AW+1)'(DEPTH));
            empty_reg  <= (count_next == '0);
            // A pop on a flush edge still delivers the head; the byte is
            // already committed to the transmitter sequencer.
            if (pop_ok) begin
                rd_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign rd_data = rd_data_reg;
    assign full    = full_reg;
    assign empty   = empty_reg;
    assign count   = count_reg;

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue feeding a UART transmitter one byte at a time.
//   clk_50m : system clock
//   rst_n   : synchronous active-low reset
//   bus     : slave side of uart_tx_queue_if (push port, status, and the
//             data_in/wr_en/Tx_busy handoff to the transmitter)
// The sequencer pops a byte only when the transmitter is idle, holds wr_en
// until Tx_busy acknowledges, then waits for Tx_busy to fall before
// returning to IDLE, guaranteeing one idle cycle between bytes.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk_50m,
    input  logic            rst_n,
    uart_tx_queue_if.slave  bus
);

    tx_q_state_t state_reg, state_next;
    logic        pop;
    logic        overflow_reg;

    sync_fifo #(
        .W     (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_50m),
        .rst_n     (rst_n),
        .push      (bus.push),
        .push_data (bus.push_data),
        .pop       (pop),
        .flush     (bus.flush),
        .rd_data   (bus.data_in),
        .full      (bus.full),
        .empty     (bus.empty),
        .count     (bus.count)
    );

    // Sticky drop indicator; flush takes priority so a push coinciding
    // with flush never sets it.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (bus.flush) begin
            overflow_reg <= 1'b0;
        end else if (bus.push && bus.full) begin
            overflow_reg <= 1'b1;
        end
    end

    assign bus.overflow = overflow_reg;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        bus.wr_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!bus.empty && !bus.Tx_busy) begin
                    pop        = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                bus.wr_en = 1'b1;
                if (bus.Tx_busy) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (!bus.Tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
